// File: rtl/iter_div_unit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, fixed
// WIDTH-cycle latency, result packed as {remainder, quotient}.
module iter_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  // The partial remainder is always below the divisor (or, for a zero divisor,
  // is just the dividend bits shifted in), so WIDTH bits hold it; only the
  // shifted trial value needs the extra bit.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // NOTE: every signal in this block is assigned on every pass with no
  // conditional paths left open, so no latch can be inferred.
  always_comb begin
    sh       = {rem, quo[WIDTH-1]};
    diff     = sh - {1'b0, dvs};
    ge       = (sh >= {1'b0, dvs});
    rem_next = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ge};
  end

  assign done = (state == S_DONE);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      c     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid) begin
            rem   <= '0;
            quo   <= a;
            dvs   <= b;
            cnt   <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          // A dropped request means the instruction was killed: abandon it.
          if (!valid) begin
            state <= S_IDLE;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              c     <= {rem_next, quo_next};
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed bench for iter_div_unit: latency, results, abort, async reset and
// back-to-back issue, each against hand-computed {remainder, quotient} values.
module tb_iter_div_unit;

  logic        clk;
  logic        resetn;
  logic        valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        done;
  logic [63:0] c;

  int total = 0;
  int bad   = 0;

  iter_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .valid  (valid),
    .a      (a),
    .b      (b),
    .done   (done),
    .c      (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts and ends just after a falling edge. Operands are scrambled mid-run
  // to confirm they are only sampled at capture.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv,
                       input logic [63:0] exp_c, input string name);
    logic        early;
    logic        moved;
    logic [63:0] c_before;
    early    = 1'b0;
    moved    = 1'b0;
    c_before = c;
    a        = ta;
    b        = tbv;
    valid    = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (done !== 1'b0) early = 1'b1;
      if (c !== c_before) moved = 1'b1;
      if (i == 4) begin
        a = ~ta;
        b = tbv ^ 32'h5A5A_0001;
      end
      @(posedge clk);
    end
    @(negedge clk);
    total++;
    if (early) begin
      bad++;
      $display("FAIL %s early_done: done=1 seen before cycle 32, required 0", name);
    end
    total++;
    if (moved) begin
      bad++;
      $display("FAIL %s c_hold: c changed while busy, required %h", name, c_before);
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s done_latency: done=%b, required 1", name, done);
    end
    total++;
    if (c !== exp_c) begin
      bad++;
      $display("FAIL %s result: c=%h, required %h", name, c, exp_c);
    end
    valid = 1'b0;
    a     = '0;
    b     = '0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL %s done_pulse: done=%b one cycle later, required 0", name, done);
    end
  endtask

  task automatic test_reset;
    logic stray;
    stray  = 1'b0;
    resetn = 1'b0;
    valid  = 1'b0;
    a      = 32'hDEAD_BEEF;
    b      = 32'h1;
    #1;
    total++;
    if (c !== 64'd0) begin
      bad++;
      $display("FAIL reset_c: c=%h, required 0", c);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: done=%b, required 0", done);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done !== 1'b0) stray = 1'b1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL idle_no_done: done=1 with valid low, required 0");
    end
  endtask

  task automatic test_basic;
    do_op(32'd100, 32'd7, {32'd2, 32'd14}, "basic_100_7");
  endtask

  task automatic test_vectors;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [63:0] vc [4];
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'd1; vc[0] = {32'h0, 32'hFFFF_FFFF};
    va[1] = 32'd5;         vb[1] = 32'd9; vc[1] = {32'd5, 32'd0};
    va[2] = 32'd0;         vb[2] = 32'd3; vc[2] = 64'd0;
    va[3] = 32'h1234_5678; vb[3] = 32'd0; vc[3] = {32'h1234_5678, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vc[i], $sformatf("vector%0d", i));
    end
  endtask

  task automatic test_abort;
    logic        stray;
    logic [63:0] prior;
    stray = 1'b0;
    prior = {32'h1234_5678, 32'hFFFF_FFFF};
    a     = 32'd50;
    b     = 32'd5;
    valid = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0) stray = 1'b1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL abort_no_done: done pulsed after abort, required none");
    end
    total++;
    if (c !== prior) begin
      bad++;
      $display("FAIL abort_c_hold: c=%h, required %h", c, prior);
    end
    do_op(32'd81, 32'd9, {32'd0, 32'd9}, "after_abort_81_9");
  endtask

  task automatic test_async_reset;
    logic stray;
    stray = 1'b0;
    a     = 32'd1000;
    b     = 32'd3;
    valid = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if (c !== 64'd0) begin
      bad++;
      $display("FAIL async_reset_c: c=%h, required 0", c);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_done: done=%b, required 0", done);
    end
    valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0) stray = 1'b1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL async_reset_stale: done pulsed after reset, required none");
    end
    do_op(32'd10, 32'd3, {32'd1, 32'd3}, "after_reset_10_3");
  endtask

  task automatic test_back_to_back;
    int gap;
    logic seen;
    gap   = 0;
    seen  = 1'b0;
    a     = 32'd100;
    b     = 32'd7;
    valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL b2b_first_done: no done within 40 cycles, required one");
    end
    total++;
    if (c !== {32'd2, 32'd14}) begin
      bad++;
      $display("FAIL b2b_first_c: c=%h, required %h", c, {32'd2, 32'd14});
    end
    a    = 32'd7;
    b    = 32'd2;
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        gap  = k;
      end
    end
    total++;
    if (gap != 34) begin
      bad++;
      $display("FAIL b2b_gap: second done %0d cycles after first, required 34", gap);
    end
    total++;
    if (c !== {32'd1, 32'd3}) begin
      bad++;
      $display("FAIL b2b_second_c: c=%h, required %h", c, {32'd1, 32'd3});
    end
    valid = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
